// File: rtl/reg_arb_pkg.sv
// -----------------------------------------------------------------------------
// reg_arb_pkg
// Shared definitions for the register write arbiter:
//   - DEF_N / DEF_W : default requester count and data width
//   - arb_state_t   : arbiter state encoding (IDLE=0, WRITE=1, ACK=2)
//   - ptr_width()   : width of the round-robin pointer / grant index
// -----------------------------------------------------------------------------
package reg_arb_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } arb_state_t;

    // Index width for N requesters; never below one bit so the pointer
    // register always exists.
    function automatic int ptr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg16_sr.sv
// -----------------------------------------------------------------------------
// reg16_sr
// W-bit load-enabled storage register with synchronous active-high reset.
// Reset takes priority over load.
// Ports:
//   CLK   in  1  clock
//   reset in  1  synchronous reset, clears the register to 0
//   load  in  1  capture 'in' on the rising edge
//   in    in  W  data to store
//   out   out W  stored value
// -----------------------------------------------------------------------------
module reg16_sr #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);

    logic [W-1:0] q_reg;

    always_ff @(posedge CLK) begin
        if (reset) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= in;
        end
    end

    assign out = q_reg;

endmodule

// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
// Round-robin request/acknowledge arbiter that serialises writes from N
// producers into one shared load-enabled register (reg16_sr).
// Each transaction takes three cycles: IDLE (select + latch data),
// WRITE (register loads), ACK (one-cycle ack pulse, pointer advances).
//
// Ports:
//   CLK    in  1    clock, all state changes on the rising edge
//   reset  in  1    synchronous active-high reset
//   req    in  N    per-requester write request, held until ack
//   wdata  in  N*W  flattened write data, requester i at [i*W +: W]
//   lock   in  N    (only with REG_WRITE_ARB_LOCK_EN) keep ownership
//   out    out W    current stored value
//   grant  out N    one-hot owner during WRITE/ACK, zero in IDLE
//   ack    out N    one-cycle completion pulse to the owner
//   busy   out 1    high whenever not IDLE
//
// Build option: define REG_WRITE_ARB_LOCK_EN to add the 'lock' input. When
// the owner holds lock during ACK the pointer is frozen and only the owner's
// request is considered until it releases lock; round-robin then resumes
// just after the owner.
// -----------------------------------------------------------------------------
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic [0:0]     CLK,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] wdata,
`ifdef REG_WRITE_ARB_LOCK_EN
    input  logic [N-1:0]   lock,
`endif
    output logic [W-1:0]   out,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   ack,
    output logic           busy
);

    localparam int PW = ptr_width(N);

    arb_state_t    state_reg, state_next;
    logic [PW-1:0] ptr_reg, ptr_next;
    logic [PW-1:0] gnt_idx_reg, gnt_idx_next;
    logic [W-1:0]  wdata_q_reg, wdata_q_next;
    logic          load;

    logic [N-1:0]   gnt_dec;       // one-hot of gnt_idx_reg
    logic [PW-1:0]  gnt_inc;       // (gnt_idx_reg + 1) mod N
    logic [N-1:0]   eff_req;       // requests eligible for this search
    logic [PW-1:0]  search_start;  // first index examined by the search
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   rot_req;       // eff_req rotated so search_start is bit 0
    logic           found;
    logic [PW-1:0]  sel_idx;

`ifdef REG_WRITE_ARB_LOCK_EN
    logic lock_flag_reg, lock_flag_next;
    logic owner_lock;
    assign owner_lock = lock[gnt_idx_reg];
`endif

    // ---------------------------------------------------------------
    // Grant index decode and wrap-around increment
    // ---------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dec
            assign gnt_dec[gi] = (gnt_idx_reg == PW'(gi));
        end
    endgenerate

    always_comb begin
        gnt_inc = (int'(gnt_idx_reg) == N - 1) ? '0 : gnt_idx_reg + 1'b1;
    end

    // ---------------------------------------------------------------
    // Request masking / search origin (lock ownership narrows the field)
    // ---------------------------------------------------------------
    always_comb begin
        eff_req      = req;
        search_start = ptr_reg;
`ifdef REG_WRITE_ARB_LOCK_EN
        if (lock_flag_reg) begin
            if (owner_lock) begin
                eff_req = req & gnt_dec;
            end else begin
                // Lock released this cycle: resume just after the owner.
                search_start = gnt_inc;
            end
        end
`endif
    end

    // ---------------------------------------------------------------
    // Round-robin search: rotate so the start index lands at bit 0, take
    // the lowest set bit, then map it back to an absolute index.
    // ---------------------------------------------------------------
    always_comb begin
        req_dbl = {eff_req, eff_req} >> search_start;
        rot_req = req_dbl[N-1:0];
        found   = 1'b0;
        sel_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot_req[k]) begin
                found   = 1'b1;
                sel_idx = PW'((int'(search_start) + k) % N);
            end
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        gnt_idx_next = gnt_idx_reg;
        wdata_q_next = wdata_q_reg;
        load         = 1'b0;
`ifdef REG_WRITE_ARB_LOCK_EN
        lock_flag_next = lock_flag_reg;
`endif
        case (state_reg)
            IDLE: begin
`ifdef REG_WRITE_ARB_LOCK_EN
                if (lock_flag_reg && !owner_lock) begin
                    lock_flag_next = 1'b0;
                    ptr_next       = gnt_inc;
                end
`endif
                if (found) begin
                    gnt_idx_next = sel_idx;
                    wdata_q_next = wdata[int'(sel_idx)*W +: W];
                    state_next   = WRITE;
                end
            end
            WRITE: begin
                load       = 1'b1;
                state_next = ACK;
            end
            ACK: begin
                state_next = IDLE;
`ifdef REG_WRITE_ARB_LOCK_EN
                if (owner_lock) begin
                    lock_flag_next = 1'b1;
                end else begin
                    lock_flag_next = 1'b0;
                    ptr_next       = gnt_inc;
                end
`else
                ptr_next = gnt_inc;
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            gnt_idx_reg <= '0;
            wdata_q_reg <= '0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            gnt_idx_reg <= gnt_idx_next;
            wdata_q_reg <= wdata_q_next;
        end
    end

`ifdef REG_WRITE_ARB_LOCK_EN
    always_ff @(posedge CLK) begin
        if (reset) begin
            lock_flag_reg <= 1'b0;
        end else begin
            lock_flag_reg <= lock_flag_next;
        end
    end
`endif

    // ---------------------------------------------------------------
    // Outputs decoded from registered state only
    // ---------------------------------------------------------------
    assign busy  = (state_reg != IDLE);
    assign grant = busy ? gnt_dec : '0;
    assign ack   = (state_reg == ACK) ? gnt_dec : '0;

    reg16_sr #(
        .W(W)
    ) u_reg (
        .CLK  (CLK[0]),
        .reset(reset),
        .load (load),
        .in   (wdata_q_reg),
        .out  (out)
    );

endmodule
